// File: rtl/up_down_counter_cfg.sv
// up_down_counter_cfg: bounded up/down counter with step, load, saturate/wrap and event flags.
// Optional sticky overflow/underflow flags are enabled by defining UDC_STICKY_FLAGS_EN.
module up_down_counter_cfg #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  lo_bound,
  input  logic [WIDTH-1:0]  hi_bound,
  input  logic              wrap_mode,
  input  logic              clr_sticky,
  output logic [WIDTH-1:0]  count,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              unf,
  output logic              cfg_err,
  output logic              ovf_sticky,
  output logic              unf_sticky
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   lim;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] clamped;
  logic [WIDTH-1:0] count_nxt;
  logic             over;
  logic             under;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             active;
  // One extra bit keeps bound comparisons free of WIDTH-bit wraparound.
  assign sum     = {1'b0, count} + (WIDTH+1)'(step);
  assign lim     = {1'b0, lo_bound} + (WIDTH+1)'(step);
  assign diff    = count - WIDTH'(step);
  assign over    = sum > {1'b0, hi_bound};
  assign under   = {1'b0, count} < lim;
  assign clamped = load_val < lo_bound ? lo_bound : load_val > hi_bound ? hi_bound : load_val;
  assign cfg_err = lo_bound > hi_bound;
  assign at_max  = count == hi_bound;
  assign at_min  = count == lo_bound;
  assign active  = !cfg_err && !load && en && step != '0;
  always_comb begin
    count_nxt = count;
    ovf_nxt   = active && up_down && over;
    unf_nxt   = active && !up_down && under;
    if (!cfg_err && load)
      count_nxt = clamped;
    else if (active && up_down)
      count_nxt = over ? (wrap_mode ? lo_bound : hi_bound) : sum[WIDTH-1:0];
    else if (active)
      count_nxt = under ? (wrap_mode ? hi_bound : lo_bound) : diff;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= lo_bound;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end
`ifdef UDC_STICKY_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= ovf_nxt || (ovf_sticky && !clr_sticky);
      unf_sticky <= unf_nxt || (unf_sticky && !clr_sticky);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign ovf_sticky = 1'b0;
  assign unf_sticky = 1'b0;
`endif
endmodule

// File: doc/up_down_counter_cfg.md
Name: up_down_counter_cfg

Overview:
- Parametrised successor to the team's 4-bit saturating up/down counter.
- Adds: configurable width, per-cycle step size, runtime lower/upper bounds, a saturate or wrap mode, a synchronous load, a count enable, and boundary/event flags.
- Used as a general position/level counter in datapath control, e.g. credit tracking and volume/threshold stepping.

Parameters:
- WIDTH, 8, counter and bound width in bits (≥2)
- STEP_W, 4, width of the step input (1 ≤ STEP_W ≤ WIDTH)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  count enable
- up_down  input  1  1 = count up, 0 = count down
- step  input  STEP_W  unsigned increment/decrement magnitude
- load  input  1  synchronous load request
- load_val  input  WIDTH  value to load
- lo_bound  input  WIDTH  inclusive lower bound (unsigned)
- hi_bound  input  WIDTH  inclusive upper bound (unsigned)
- wrap_mode  input  1  0 = saturate at bound, 1 = wrap to opposite bound
- clr_sticky  input  1  clears sticky flags (optional feature)
- count  output  WIDTH  registered counter value
- at_max  output  1  combinational: count == hi_bound
- at_min  output  1  combinational: count == lo_bound
- ovf  output  1  registered 1-cycle pulse: upward bound crossing attempted
- unf  output  1  registered 1-cycle pulse: downward bound crossing attempted
- cfg_err  output  1  combinational: lo_bound > hi_bound
- ovf_sticky  output  1  sticky overflow (optional feature)
- unf_sticky  output  1  sticky underflow (optional feature)

Behaviour:
- Reset, evaluated at posedge clk when rst=1:
  - count <= lo_bound value sampled that cycle.
  - ovf, unf, ovf_sticky, unf_sticky <= 0.
  - rst overrides every other input.
- Priority per cycle: rst > cfg_err > load > en. All updates are registered, with 1-cycle latency.
- cfg_err=1:
  - count holds.
  - ovf and unf are 0.
  - load and en are ignored.
- load=1:
  - count <= load_val, clamped into [lo_bound, hi_bound]: values below clamp to lo, values above clamp to hi.
  - ovf and unf are 0, even if clamping occurred.
  - en is ignored that cycle.
- en=0 or step=0: count holds; ovf and unf are 0.
- Arithmetic: computed in WIDTH+1 bits, with step zero-extended. No native wrap of the WIDTH-bit register is permitted.
- Up (en=1, up_down=1):
  - If count+step ≤ hi_bound: count <= count+step.
  - Otherwise, ovf=1 next cycle. Saturate mode: count <= hi_bound. Wrap mode: count <= lo_bound.
  - Pressing up while already at_max in saturate mode holds count and still pulses ovf.
- Down (en=1, up_down=0):
  - If count ≥ lo_bound+step (compared in WIDTH+1 bits): count <= count−step.
  - Otherwise, unf=1 next cycle. Saturate mode: count <= lo_bound. Wrap mode: count <= hi_bound.
- lo_bound == hi_bound: any nonzero step pulses ovf or unf, and count stays at the bound.
- Bound change mid-operation:
  - Bounds are not re-applied to an out-of-range count until the next load, count step, or reset.
  - An out-of-range count stepped toward the range uses the normal rules above.
  - Consequently, a count above hi stepping up is treated as overflow, and a count below lo stepping down is treated as underflow.
- ovf and unf are never both 1. Each is high for exactly one cycle per offending step.

Optional Feature:
- Macro: UDC_STICKY_FLAGS_EN.
- Defined:
  - ovf_sticky is set on any cycle where ovf is set; unf_sticky is set on any cycle where unf is set.
  - Both stay set until clr_sticky=1 or rst.
  - If clr_sticky and a new event occur in the same cycle, the set wins.
- Not defined:
  - ovf_sticky and unf_sticky are tied to 0.
  - clr_sticky is ignored.
  - The port list is unchanged.

Test Plan:
- Reset with lo=10, hi=200 → count=10, all flags 0. Assert rst mid-count from count=57 → count=10 on the next edge.
- Saturate up: lo=0, hi=200, count=195, step=4, up, two cycles → count 199 then 200, ovf pulses on the second; a third up step holds 200 and pulses ovf again.
- Wrap down: lo=5, hi=20, wrap_mode=1, count=7, step=3, down → count=20, unf=1 for one cycle; next step → 17, unf=0.
- Load clamping: lo=16, hi=64, load_val=100 → 64; load_val=3 → 16; load and en together with up step=1 → load wins, count=load result.
- Full-range WIDTH=8: lo=0, hi=255, count=250, step=15, up, saturate → 255 with ovf (no native 8-bit wrap to 9). cfg_err case: lo=30, hi=20 → cfg_err=1, count holds through en/load.
- With UDC_STICKY_FLAGS_EN: generate ovf → ovf_sticky stays 1 for 10 cycles; clr_sticky clears it; clr_sticky coincident with a new unf → unf_sticky=1.
